// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_checker
//  Purpose  : Exhaustively sweeps the eight input vectors {x,y,z} of a
//             3-input combinational block, holds each vector for SETTLE_CYC
//             cycles, samples the block output f on the last held cycle and
//             compares it with a captured expected truth table.
//
//  Ports    : clk           - rising-edge clock
//             rst_n         - asynchronous active-low reset
//             start         - begin a sweep (pulse or level, accepted in IDLE)
//             exp_tt[7:0]   - expected truth table, bit i = f for vector i
//             f             - output of the block under check
//             x, y, z       - vector driven to the block (x = MSB)
//             busy          - high while sweeping
//             done          - one-cycle completion pulse
//             pass          - last completed sweep had no mismatches
//             mismatch_mask - bit i set when vector i mismatched
//             err_count     - number of mismatching vectors (0..8)
//
//  Revision : 1.0 - initial release
// ============================================================================
module truth_table_checker #(
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] exp_tt,
  input  logic       f,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] mismatch_mask,
  output logic [3:0] err_count
);

  // Settle counter value on which f is sampled.
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] ERR_MAX  = 4'd8;
  localparam logic [2:0] IDX_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] tt_q;     // truth table captured at start
  logic [2:0] idx;      // current vector index
  logic [3:0] cnt;      // settle counter within the current vector
  logic       pass_q;   // pass result held between sweeps

  logic       sample;   // this RUN cycle is the one where f is judged
  logic       miss;     // f disagrees with the captured table on that cycle

  assign sample = (state == RUN) && (cnt == LAST_CNT);
  assign miss   = sample && (f != tt_q[idx]);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    x         = 1'b0;
    y         = 1'b0;
    z         = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = pass_q;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        busy = 1'b1;
        {x, y, z} = idx;
        if (sample && (idx == IDX_LAST)) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        done = 1'b1;
        // err_count is final here, so the verdict is visible alongside done
        // and is latched into pass_q on the way back to IDLE.
        pass = (err_count == 4'd0);
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: capture, vector stepping, mismatch accumulation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q          <= 8'h00;
      idx           <= 3'd0;
      cnt           <= 4'd0;
      pass_q        <= 1'b0;
      mismatch_mask <= 8'h00;
      err_count     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tt_q          <= exp_tt;
            idx           <= 3'd0;
            cnt           <= 4'd0;
            pass_q        <= 1'b0;
            mismatch_mask <= 8'h00;
            err_count     <= 4'd0;
          end
        end

        RUN: begin
          if (sample) begin
            cnt <= 4'd0;
            // idx stays at 7 on the final vector; outputs are gated off
            // outside RUN and the next start reloads it.
            if (idx != IDX_LAST) begin
              idx <= idx + 3'd1;
            end
            if (miss) begin
              mismatch_mask[idx] <= 1'b1;
              if (err_count != ERR_MAX) begin
                err_count <= err_count + 4'd1;
              end
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          pass_q <= (err_count == 4'd0);
        end

        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_truth_table_checker
//  Purpose  : Directed self-checking bench for truth_table_checker. Two
//             instances: SETTLE_CYC=4 (main scenarios) and SETTLE_CYC=1
//             (minimum settle time). f is produced by a small model of the
//             block under check: majority, stuck-at-0, or inverted majority.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

  logic       clk;
  logic       rst_n;

  // SETTLE_CYC = 4 instance
  logic       start4;
  logic [7:0] exp_tt4;
  logic       f4;
  logic       x4, y4, z4, busy4, done4, pass4;
  logic [7:0] mask4;
  logic [3:0] err4;
  int         mode4;   // 0 majority, 1 stuck-at-0, 2 inverted majority

  // SETTLE_CYC = 1 instance
  logic       start1;
  logic [7:0] exp_tt1;
  logic       f1;
  logic       x1, y1, z1, busy1, done1, pass1;
  logic [7:0] mask1;
  logic [3:0] err1;

  int n_vec;
  int n_miss;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    case (mode4)
      1:       f4 = 1'b0;
      2:       f4 = ~maj(x4, y4, z4);
      default: f4 = maj(x4, y4, z4);
    endcase
  end

  assign f1 = maj(x1, y1, z1);

  truth_table_checker #(.SETTLE_CYC(4)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start4),
    .exp_tt        (exp_tt4),
    .f             (f4),
    .x             (x4),
    .y             (y4),
    .z             (z4),
    .busy          (busy4),
    .done          (done4),
    .pass          (pass4),
    .mismatch_mask (mask4),
    .err_count     (err4)
  );

  truth_table_checker #(.SETTLE_CYC(1)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start1),
    .exp_tt        (exp_tt1),
    .f             (f1),
    .x             (x1),
    .y             (y1),
    .z             (z1),
    .busy          (busy1),
    .done          (done1),
    .pass          (pass1),
    .mismatch_mask (mask1),
    .err_count     (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_results4(input string tag, input logic [7:0] m,
                                input logic [3:0] e, input logic p);
    check({tag, "_mask"}, 32'(mask4), 32'(m));
    check({tag, "_err"},  32'(err4),  32'(e));
    check({tag, "_pass"}, 32'(pass4), 32'(p));
  endtask

  // One full sweep on the SETTLE_CYC=4 instance. The cycle-by-cycle checks
  // cover vector order, hold time and the done latency: counting the
  // accepting edge as edge 1, done is seen after edge 33.
  // repulse >= 0 raises start for that one RUN cycle; hold keeps start high
  // through the whole sweep and leaves it high on return.
  task automatic sweep4(input logic [7:0] tt, input int fmode,
                        input int repulse, input bit hold);
    @(negedge clk);
    exp_tt4 = tt;
    mode4   = fmode;
    start4  = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (!hold) start4 = (k == repulse);
      exp_tt4 = ~tt;   // captured table must be unaffected
      check("run_busy", 32'(busy4), 32'd1);
      check("run_done", 32'(done4), 32'd0);
      check("run_xyz",  32'({x4, y4, z4}), 32'(k / 4));
    end
    @(negedge clk);
    if (!hold) start4 = 1'b0;
    exp_tt4 = tt;
    check("done_pulse", 32'(done4), 32'd1);
    check("done_busy",  32'(busy4), 32'd0);
    check("done_xyz",   32'({x4, y4, z4}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit saw_done;
    n_vec   = 0;
    n_miss  = 0;
    rst_n   = 1'b0;
    start4  = 1'b0;
    start1  = 1'b0;
    exp_tt4 = 8'hE8;
    exp_tt1 = 8'hE8;
    mode4   = 0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_xyz",  32'({x4, y4, z4}), 32'd0);
    check_results4("rst", 8'h00, 4'd0, 1'b0);
    check("rst1_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct majority block
    sweep4(8'hE8, 0, -1, 1'b0);
    check_results4("maj", 8'h00, 4'd0, 1'b1);
    @(negedge clk);
    check("maj_idle_busy", 32'(busy4), 32'd0);
    check("maj_idle_done", 32'(done4), 32'd0);
    check_results4("maj_idle", 8'h00, 4'd0, 1'b1);

    // Stuck-at-0 block: vectors 3,5,6,7 expected 1
    sweep4(8'hE8, 1, -1, 1'b0);
    check_results4("sa0", 8'hE8, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_tt4 = 8'h5A;
      mode4   = 0;
    end
    check_results4("sa0_hold", 8'hE8, 4'd4, 1'b0);
    check("sa0_hold_xyz", 32'({x4, y4, z4}), 32'd0);

    // Inverted block: every vector wrong, count reaches 8
    sweep4(8'hE8, 2, -1, 1'b0);
    check_results4("inv", 8'hFF, 4'd8, 1'b0);

    // Parity table vs majority block (E8 ^ 96 = 7E), start re-pulsed mid-run
    sweep4(8'h96, 0, 10, 1'b0);
    check_results4("par", 8'h7E, 4'd6, 1'b0);

    // Start held through DONE: IDLE one cycle, busy two edges after done
    sweep4(8'hE8, 0, -1, 1'b1);
    check("hold_pass", 32'(pass4), 32'd1);
    @(negedge clk);
    check("hold_idle_busy", 32'(busy4), 32'd0);
    @(negedge clk);
    check("hold_restart_busy", 32'(busy4), 32'd1);

    // Reset while idx==3
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if ({x4, y4, z4} == 3'd3) found = 1'b1;
    end
    check("idx3_reached", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy4), 32'd0);
    check("arst_xyz",  32'({x4, y4, z4}), 32'd0);
    check("arst_done", 32'(done4), 32'd0);
    check_results4("arst", 8'h00, 4'd0, 1'b0);
    @(negedge clk);
    check("arst_held_busy", 32'(busy4), 32'd0);
    rst_n  = 1'b1;
    start4 = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4 || busy4) saw_done = 1'b1;
    end
    check("arst_no_done", 32'(saw_done), 32'd0);
    sweep4(8'hE8, 0, -1, 1'b0);
    check_results4("after_rst", 8'h00, 4'd0, 1'b1);

    // SETTLE_CYC=1: start accepted on the first edge after reset release,
    // one cycle per vector, done seen after edge 9 counting the accept edge.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    start1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      check("s1_busy", 32'(busy1), 32'd1);
      check("s1_xyz",  32'({x1, y1, z1}), 32'(k));
    end
    @(negedge clk);
    check("s1_done", 32'(done1), 32'd1);
    check("s1_pass", 32'(pass1), 32'd1);
    check("s1_mask", 32'(mask1), 32'd0);
    check("s1_err",  32'(err1),  32'd0);
    @(negedge clk);
    check("s1_idle_done", 32'(done1), 32'd0);
    check("s1_idle_pass", 32'(pass1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
